micro_hash: RTL and testbench
=============================

Name: micro_hash

Overview:
- Byte-serial 24-bit "micro hash" engine, one round per clock.
- Sits directly downstream of the nonce-iterating miner. The miner presents the 96-bit block header plus a 32-bit candidate nonce and pulses inicio.
- The block returns the 24-bit hash, a target-met flag and a one-cycle terminado pulse.
- The miner uses cumple to decide whether to stop or advance the nonce.

Parameters:
H_INIT, 24'h0189FE, initial hash state {H0,H1,H2}
K_LO, 8'h99, round constant for rounds 0..16
K_HI, 8'hA1, round constant for rounds 17..31

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high; one clock, reset sampled on posedge clk
inicio  input  1  start request, sampled only in IDLE
bloque_bytes  input  96  block header, byte 0 = bits [95:88]
nonce  input  32  candidate nonce, byte 0 = bits [31:24]
target  input  8  difficulty threshold
ocupado  output  1  high from the accepting edge until terminado
terminado  output  1  one-cycle completion pulse
hash  output  24  result {H0,H1,H2}, held until the next completion
cumple  output  1  (hash[23:16] < target) && (hash[15:8] < target); valid when terminado=1 and held with hash

Behaviour:
- Reset (reset=1 at posedge): state=IDLE; ocupado=0, terminado=0, hash=24'h0, cumple=0. Message store and round counter are cleared.
- Reset mid-operation aborts the computation with no terminado pulse. Reset has priority over everything.
- States: IDLE -> ROUND -> FINAL -> IDLE.
- IDLE:
  - With inicio=1, the edge (E0) latches W[0..11] = bloque_bytes bytes MSB-first, W[12..15] = nonce bytes MSB-first, and target.
  - It sets a,b,c = H_INIT bytes, i=0, ocupado=1, next=ROUND.
  - inicio=0 leaves the state unchanged.
- ROUND (edges E1..E32, round i = 0..31, one round per edge):
  - w = W[i] for i<16, else W[i-3] | (W[i-9] ^ W[i-14]). For i>=16, w is written back into W[i].
  - x = a ^ b for i<=16, else a ^ b ^ c.
  - k = K_LO for i<=16, else K_HI.
  - a' = b ^ c; b' = {c[3:0], c[7:4]}; c' = (a + x + k + w) mod 256.
  - After i=31, next=FINAL.
- FINAL (edge E33):
  - hash = {H0+a, H1+b, H2+c}, each byte sum mod 256.
  - cumple computed from the new hash and the latched target.
  - terminado=1 for exactly this cycle; ocupado=0; next=IDLE.
- Latency:
  - hash, cumple and terminado are visible 33 cycles after the accepting edge.
  - Back-to-back operation: inicio held high re-accepts on the edge after FINAL, giving a 34-cycle throughput.
- inicio while ocupado=1 is ignored, and inputs are not re-sampled. bloque_bytes, nonce and target may change after E0 without effect.
- All byte arithmetic wraps mod 256; no carries between bytes.
- target=8'h00 means cumple is always 0.
- hash/cumple are unchanged between completions and between reset and first completion (zero).

Test Plan:
- Reset then idle: reset high 3 cycles, release, 20 idle cycles -> hash=0, cumple=0, terminado=0, ocupado=0 throughout.
- Single op, bloque_bytes=96'h0123456789ABCDEF01234567, nonce=32'h00000000, target=8'hFF, inicio pulsed once:
  - ocupado rises the cycle after the accept edge.
  - terminado pulses exactly once, 33 cycles after acceptance.
  - hash equals the bench reference model; cumple = model comparison.
- Determinism/sensitivity: repeat the same inputs -> identical hash. Then nonce=32'h00000001 -> hash equals the model value and differs from the first.
- Busy rejection: during the op, pulse inicio at cycle 10 with different bloque_bytes -> single terminado at cycle 33 with the original hash; no second operation starts.
- Reset mid-op: assert reset at round 15 -> no terminado; hash=0; ocupado=0. A new inicio then completes normally in 33 cycles.
- Target boundary: same block with target=8'h00 -> cumple=0. With target = max(hash[23:16], hash[15:8]) + 1 (from the model) -> cumple=1. With target equal to that max -> cumple=0.

Source files
------------

// File: rtl/micro_hash.sv
// Byte-serial 24-bit micro hash: 16-byte message (header + nonce) mixed over
// 32 rounds, one round per clock, then folded into the initial state.
module micro_hash #(
    parameter logic [23:0] H_INIT = 24'h0189FE,
    parameter logic [7:0]  K_LO   = 8'h99,
    parameter logic [7:0]  K_HI   = 8'hA1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inicio,
    input  logic [95:0] bloque_bytes,
    input  logic [31:0] nonce,
    input  logic [7:0]  target,
    output logic        ocupado,
    output logic        terminado,
    output logic [23:0] hash,
    output logic        cumple
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL
    } state_t;

    state_t     r_state;
    logic [7:0] r_w [0:31];
    logic [4:0] r_i;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_c;
    logic [7:0] r_target;

    logic [4:0]  w_im3;
    logic [4:0]  w_im9;
    logic [4:0]  w_im14;
    logic        w_early;
    logic [7:0]  w_wi;
    logic [7:0]  w_x;
    logic [7:0]  w_k;
    logic [7:0]  w_c_next;
    logic [23:0] w_hash;
    logic        w_cumple;

    // Rounds 16 and up extend the message from earlier schedule words.
    always_comb begin
        w_im3    = r_i - 5'd3;
        w_im9    = r_i - 5'd9;
        w_im14   = r_i - 5'd14;
        w_early  = (r_i <= 5'd16);
        w_wi     = (r_i < 5'd16) ? r_w[r_i]
                                 : (r_w[w_im3] | (r_w[w_im9] ^ r_w[w_im14]));
        w_x      = w_early ? (r_a ^ r_b) : (r_a ^ r_b ^ r_c);
        w_k      = w_early ? K_LO : K_HI;
        w_c_next = r_a + w_x + w_k + w_wi;
        w_hash   = {H_INIT[23:16] + r_a, H_INIT[15:8] + r_b, H_INIT[7:0] + r_c};
        w_cumple = (w_hash[23:16] < r_target) && (w_hash[15:8] < r_target);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            ocupado   <= 1'b0;
            terminado <= 1'b0;
            hash      <= 24'h0;
            cumple    <= 1'b0;
            r_i       <= 5'd0;
            r_a       <= 8'h0;
            r_b       <= 8'h0;
            r_c       <= 8'h0;
            r_target  <= 8'h0;
            for (int j = 0; j < 32; j++) begin
                r_w[j] <= 8'h0;
            end
        end else begin
            terminado <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (inicio) begin
                        for (int j = 0; j < 12; j++) begin
                            r_w[j] <= bloque_bytes[95 - 8*j -: 8];
                        end
                        for (int j = 0; j < 4; j++) begin
                            r_w[12 + j] <= nonce[31 - 8*j -: 8];
                        end
                        r_target <= target;
                        r_a      <= H_INIT[23:16];
                        r_b      <= H_INIT[15:8];
                        r_c      <= H_INIT[7:0];
                        r_i      <= 5'd0;
                        ocupado  <= 1'b1;
                        r_state  <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (r_i >= 5'd16) begin
                        r_w[r_i] <= w_wi;
                    end
                    r_a <= r_b ^ r_c;
                    r_b <= {r_c[3:0], r_c[7:4]};
                    r_c <= w_c_next;
                    r_i <= r_i + 5'd1;
                    if (r_i == 5'd31) begin
                        r_state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    hash      <= w_hash;
                    cumple    <= w_cumple;
                    terminado <= 1'b1;
                    ocupado   <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_micro_hash.sv
// Scoreboard bench for micro_hash: stimulus pushes expected results, a monitor
// pops and compares them on every terminado pulse.
module tb_micro_hash;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicio;
    logic [95:0] bloque_bytes;
    logic [31:0] nonce;
    logic [7:0]  target;
    logic        ocupado;
    logic        terminado;
    logic [23:0] hash;
    logic        cumple;

    always #5 clk = ~clk;

    micro_hash dut (
        .clk          (clk),
        .reset        (reset),
        .inicio       (inicio),
        .bloque_bytes (bloque_bytes),
        .nonce        (nonce),
        .target       (target),
        .ocupado      (ocupado),
        .terminado    (terminado),
        .hash         (hash),
        .cumple       (cumple)
    );

    typedef struct {
        logic [23:0] h;
        logic        c;
        int          acc;
    } exp_t;

    exp_t expQ[$];
    int   nChecks   = 0;
    int   nFails    = 0;
    int   cycle     = 0;
    int   doneCount = 0;

    localparam logic [95:0] B0 = 96'h0123456789ABCDEF01234567;
    localparam logic [95:0] B1 = 96'hFFFFFFFFFFFFFFFFFFFFFFFF;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        nChecks++;
        if (act !== expv) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [23:0] modelHash(input logic [95:0] blk, input logic [31:0] n);
        logic [7:0] w [0:31];
        logic [7:0] a, b, c, x, k, wv, na, nb, nc;
        for (int j = 0; j < 32; j++) w[j] = 8'h0;
        for (int j = 0; j < 12; j++) w[j] = blk[95 - 8*j -: 8];
        for (int j = 0; j < 4; j++) w[12 + j] = n[31 - 8*j -: 8];
        a = 8'h01; b = 8'h89; c = 8'hFE;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) begin
                wv = w[i];
            end else begin
                wv = w[i-3] | (w[i-9] ^ w[i-14]);
                w[i] = wv;
            end
            x  = (i <= 16) ? (a ^ b) : (a ^ b ^ c);
            k  = (i <= 16) ? 8'h99 : 8'hA1;
            nc = a + x + k + wv;
            nb = {c[3:0], c[7:4]};
            na = b ^ c;
            a = na; b = nb; c = nc;
        end
        modelHash = {8'h01 + a, 8'h89 + b, 8'hFE + c};
    endfunction

    function automatic logic cumpleOf(input logic [23:0] h, input logic [7:0] t);
        cumpleOf = (h[23:16] < t) && (h[15:8] < t);
    endfunction

    // Monitor: every terminado must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (terminado) begin
            doneCount++;
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected terminado: got hash %h, expected no completion", hash);
            end else begin
                e = expQ.pop_front();
                checkOutput("hash", {8'h0, hash}, {8'h0, e.h});
                checkOutput("cumple", {31'h0, cumple}, {31'h0, e.c});
                checkOutput("latency", cycle - e.acc, 33);
            end
        end
    end

    task automatic applyStimulus(input logic [95:0] blk, input logic [31:0] n,
                                 input logic [7:0] t, input logic expC);
        exp_t e;
        @(negedge clk);
        bloque_bytes = blk;
        nonce        = n;
        target       = t;
        inicio       = 1'b1;
        e.h   = modelHash(blk, n);
        e.c   = expC;
        e.acc = cycle + 1;
        expQ.push_back(e);
        @(posedge clk);
        #1 checkOutput("ocupado rise", {31'h0, ocupado}, 1);
        @(negedge clk);
        inicio = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int k;
        k = 0;
        while (expQ.size() != 0 && k < budget) begin
            @(posedge clk);
            #1 k++;
        end
        checkOutput("completion timeout", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        logic [23:0] h0, h1;
        logic [7:0]  m;
        int          d0;
        exp_t        e;

        reset = 1'b1; inicio = 1'b0;
        bloque_bytes = '0; nonce = '0; target = '0;
        repeat (3) @(posedge clk);
        #1 checkOutput("reset hash", {8'h0, hash}, 0);
        checkOutput("reset ocupado", {31'h0, ocupado}, 0);
        @(negedge clk) reset = 1'b0;

        $display("[TB] idle after reset");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 checkOutput("idle hash", {8'h0, hash}, 0);
            checkOutput("idle cumple", {31'h0, cumple}, 0);
            checkOutput("idle terminado", {31'h0, terminado}, 0);
            checkOutput("idle ocupado", {31'h0, ocupado}, 0);
        end

        $display("[TB] single operation");
        h0 = modelHash(B0, 32'h0);
        applyStimulus(B0, 32'h0, 8'hFF, cumpleOf(h0, 8'hFF));
        waitIdle(60);
        repeat (5) @(posedge clk);
        #1 checkOutput("hash held", {8'h0, hash}, {8'h0, h0});

        $display("[TB] determinism and nonce sensitivity");
        applyStimulus(B0, 32'h0, 8'hFF, cumpleOf(h0, 8'hFF));
        waitIdle(60);
        h1 = modelHash(B0, 32'h1);
        applyStimulus(B0, 32'h1, 8'hFF, cumpleOf(h1, 8'hFF));
        waitIdle(60);
        checkOutput("nonce changes hash", {31'h0, hash != h0}, 1);
        applyStimulus(B1, 32'hFFFFFFFF, 8'h80, cumpleOf(modelHash(B1, 32'hFFFFFFFF), 8'h80));
        waitIdle(60);

        $display("[TB] busy rejection");
        @(posedge clk);
        #1 d0 = doneCount;
        applyStimulus(B0, 32'h0, 8'hFF, cumpleOf(h0, 8'hFF));
        repeat (9) @(negedge clk);
        bloque_bytes = ~B0; nonce = 32'hDEADBEEF; target = 8'h00; inicio = 1'b1;
        @(negedge clk) inicio = 1'b0;
        waitIdle(60);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 checkOutput("no second op", {31'h0, ocupado}, 0);
        end
        checkOutput("single terminado", doneCount - d0, 1);

        $display("[TB] reset mid-operation");
        @(posedge clk);
        #1 d0 = doneCount;
        applyStimulus(B0, 32'h0, 8'hFF, cumpleOf(h0, 8'hFF));
        repeat (15) @(negedge clk);
        reset = 1'b1;
        expQ.delete();
        @(negedge clk) reset = 1'b0;
        repeat (40) @(posedge clk);
        #1 checkOutput("abort hash", {8'h0, hash}, 0);
        checkOutput("abort ocupado", {31'h0, ocupado}, 0);
        checkOutput("abort cumple", {31'h0, cumple}, 0);
        checkOutput("abort no terminado", doneCount - d0, 0);
        applyStimulus(B0, 32'h0, 8'hFF, cumpleOf(h0, 8'hFF));
        waitIdle(60);

        $display("[TB] target boundaries");
        m = (h0[23:16] > h0[15:8]) ? h0[23:16] : h0[15:8];
        applyStimulus(B0, 32'h0, 8'h00, 1'b0);
        waitIdle(60);
        applyStimulus(B0, 32'h0, m, 1'b0);
        waitIdle(60);
        if (m != 8'hFF) begin
            applyStimulus(B0, 32'h0, m + 8'h1, 1'b1);
            waitIdle(60);
        end

        $display("[TB] back-to-back");
        @(negedge clk);
        bloque_bytes = B0; nonce = 32'h1; target = 8'hFF; inicio = 1'b1;
        e.h = h1; e.c = cumpleOf(h1, 8'hFF); e.acc = cycle + 1;
        expQ.push_back(e);
        e.acc = cycle + 35;
        expQ.push_back(e);
        repeat (35) @(posedge clk);
        @(negedge clk) inicio = 1'b0;
        waitIdle(80);
        checkOutput("back-to-back idle", {31'h0, ocupado}, 0);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
